// File: rtl/eth_pause_pkg.sv
// Shared constants, FSM state type and wire-order helpers for the 802.3x PAUSE generator.
package eth_pause_pkg;

    localparam logic [47:0] PAUSE_DA         = 48'h0180C2000001;
    localparam logic [15:0] PAUSE_ETYPE      = 16'h8808;
    localparam logic [15:0] PAUSE_OPCODE     = 16'h0001;
    localparam int          PAUSE_BEATS      = 8;
    localparam logic [2:0]  PAUSE_LAST_BEAT  = 3'(PAUSE_BEATS - 1);
    localparam logic [3:0]  PAUSE_LAST_TUSER = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        GEN  = 2'd2
    } pause_state_e;

    // Byte 0 of a field travels first on the wire, so it lands in the lowest lane.
    function automatic logic [15:0] wire16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [47:0] wire48(input logic [47:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24], v[39:32], v[47:40]};
    endfunction

endpackage

// File: rtl/eth_pause_frame_rom.sv
// Combinational beat generator: beat index, source MAC and quanta to 64-bit frame data.
module eth_pause_frame_rom
    import eth_pause_pkg::*;
(
    input  logic [2:0]  beat_i,
    input  logic [47:0] mac_i,
    input  logic [15:0] quanta_i,
    output logic [63:0] data_o
);

    logic [47:0] da_w;
    logic [47:0] sa_w;

    assign da_w = wire48(PAUSE_DA);
    assign sa_w = wire48(mac_i);

    // Beats 3..7 are the zero pad that brings the frame to 60 bytes.
    always_comb begin
        data_o = 64'd0;
        case (beat_i)
            3'd0:    data_o = {sa_w[15:0], da_w};
            3'd1:    data_o = {wire16(PAUSE_OPCODE), wire16(PAUSE_ETYPE), sa_w[47:16]};
            3'd2:    data_o = {48'd0, wire16(quanta_i)};
            default: data_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/eth_pause_frame_gen.sv
// Inserts 802.3x XOFF/XON PAUSE frames into a 64-bit MAC TX stream at packet boundaries,
// driven by a level pause request with optional periodic XOFF refresh.
module eth_pause_frame_gen
    import eth_pause_pkg::*;
#(
    parameter int ENET_W    = 64,
    parameter int REFRESH_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [47:0]          my_mac,
    input  logic [15:0]          pause_quanta,
    input  logic [REFRESH_W-1:0] refresh_interval,
    input  logic                 pause_req,
    input  logic [ENET_W-1:0]    i_tdata,
    input  logic [3:0]           i_tuser,
    input  logic                 i_tlast,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [ENET_W-1:0]    o_tdata,
    output logic [3:0]           o_tuser,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic                 pause_sent,
    output logic                 xon_sent
);

    if (ENET_W != 64) begin : g_enet_w_check
        $error("eth_pause_frame_gen supports ENET_W == 64 only");
    end

    pause_state_e         state_q, state_d;
    logic [2:0]           beat_q, beat_d;
    logic                 req_q;
    logic                 xoff_pend_q, xoff_pend_d;
    logic                 xon_pend_q, xon_pend_d;
    logic [REFRESH_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [47:0]          mac_q;
    logic [15:0]          quanta_q;
    logic                 is_xon_q;

    logic                 rise_s;
    logic                 fall_s;
    logic                 refresh_on_s;
    logic                 refresh_hit_s;
    logic                 first_acc_s;
    logic                 gen_start_s;
    logic [REFRESH_W-1:0] reload_s;
    logic [63:0]          rom_data_s;

    assign rise_s        = pause_req & ~req_q;
    assign fall_s        = ~pause_req & req_q;
    assign refresh_on_s  = req_q && (refresh_interval != {REFRESH_W{1'b0}});
    assign refresh_hit_s = refresh_on_s && (refresh_cnt_q == {REFRESH_W{1'b0}});
    assign reload_s      = refresh_interval - {{(REFRESH_W-1){1'b0}}, 1'b1};
    assign first_acc_s   = (state_q == GEN) && (beat_q == 3'd0) && o_tready;

    eth_pause_frame_rom u_rom (
        .beat_i   (beat_q),
        .mac_i    (mac_q),
        .quanta_i (quanta_q),
        .data_o   (rom_data_s)
    );

    // Pending flags and refresh countdown; request edges outrank the first-beat clear.
    always_comb begin
        xoff_pend_d   = xoff_pend_q;
        xon_pend_d    = xon_pend_q;
        refresh_cnt_d = refresh_cnt_q;

        if (fall_s) begin
            xoff_pend_d = 1'b0;
        end else if (rise_s || refresh_hit_s) begin
            xoff_pend_d = 1'b1;
        end else if (first_acc_s && !is_xon_q) begin
            xoff_pend_d = 1'b0;
        end else begin
            xoff_pend_d = xoff_pend_q;
        end

        if (fall_s) begin
            xon_pend_d = 1'b1;
        end else if (rise_s) begin
            xon_pend_d = 1'b0;
        end else if (first_acc_s && is_xon_q) begin
            xon_pend_d = 1'b0;
        end else begin
            xon_pend_d = xon_pend_q;
        end

        if (rise_s) begin
            refresh_cnt_d = reload_s;
        end else if (refresh_on_s) begin
            refresh_cnt_d = refresh_hit_s ? reload_s
                                          : refresh_cnt_q - {{(REFRESH_W-1){1'b0}}, 1'b1};
        end else begin
            refresh_cnt_d = refresh_cnt_q;
        end
    end

    // Stream FSM: arbitration only in IDLE, so a packet is never cut by a PAUSE frame.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        gen_start_s = 1'b0;
        o_tdata     = {ENET_W{1'b0}};
        o_tuser     = 4'd0;
        o_tlast     = 1'b0;
        o_tvalid    = 1'b0;
        i_tready    = 1'b0;
        pause_sent  = 1'b0;
        xon_sent    = 1'b0;

        if (rst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xon_pend_q || xoff_pend_q) begin
                        gen_start_s = 1'b1;
                        state_d     = GEN;
                    end else if (i_tvalid) begin
                        o_tdata  = i_tdata;
                        o_tuser  = i_tuser;
                        o_tlast  = i_tlast;
                        o_tvalid = 1'b1;
                        i_tready = o_tready;
                        // A stalled first beat commits to PASS so o_tvalid cannot drop.
                        state_d  = (o_tready && i_tlast) ? IDLE : PASS;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PASS: begin
                    o_tdata  = i_tdata;
                    o_tuser  = i_tuser;
                    o_tlast  = i_tlast;
                    o_tvalid = i_tvalid;
                    i_tready = o_tready;
                    if (i_tvalid && o_tready && i_tlast) begin
                        state_d = IDLE;
                    end else begin
                        state_d = PASS;
                    end
                end
                GEN: begin
                    o_tdata  = rom_data_s;
                    o_tlast  = (beat_q == PAUSE_LAST_BEAT);
                    o_tuser  = (beat_q == PAUSE_LAST_BEAT) ? PAUSE_LAST_TUSER : 4'd0;
                    o_tvalid = 1'b1;
                    if (o_tready) begin
                        beat_d = beat_q + 3'd1;
                        if (beat_q == PAUSE_LAST_BEAT) begin
                            pause_sent = 1'b1;
                            xon_sent   = is_xon_q;
                            state_d    = IDLE;
                        end else begin
                            state_d = GEN;
                        end
                    end else begin
                        beat_d = beat_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, flag, counter and frame-field registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            beat_q        <= 3'd0;
            req_q         <= 1'b0;
            xoff_pend_q   <= 1'b0;
            xon_pend_q    <= 1'b0;
            refresh_cnt_q <= {REFRESH_W{1'b0}};
            mac_q         <= 48'd0;
            quanta_q      <= 16'd0;
            is_xon_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            req_q         <= pause_req;
            xoff_pend_q   <= xoff_pend_d;
            xon_pend_q    <= xon_pend_d;
            refresh_cnt_q <= refresh_cnt_d;
            if (gen_start_s) begin
                mac_q    <= my_mac;
                quanta_q <= xon_pend_q ? 16'd0 : pause_quanta;
                is_xon_q <= xon_pend_q;
            end
        end
    end

endmodule

// File: tb/tb_eth_pause_frame_gen.sv
// Directed self-checking bench for eth_pause_frame_gen.
module tb_eth_pause_frame_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] my_mac;
    logic [15:0] pause_quanta;
    logic [15:0] refresh_interval;
    logic        pause_req;
    logic [63:0] i_tdata;
    logic [3:0]  i_tuser;
    logic        i_tlast, i_tvalid, i_tready;
    logic [63:0] o_tdata;
    logic [3:0]  o_tuser;
    logic        o_tlast, o_tvalid, o_tready;
    logic        pause_sent, xon_sent;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [63:0] exp_xoff [8];
    logic [63:0] exp_xon  [8];

    logic [63:0] cap_data [8];
    logic [3:0]  cap_user [8];
    logic        cap_last [8];
    logic        cap_ps   [8];
    logic        cap_xs   [8];
    int          cap_beats, cap_first, cap_stall_err, cap_start_cyc;

    logic [15:0] ready_pat = 16'b1011_0010_0110_1101;

    eth_pause_frame_gen #(.ENET_W(64), .REFRESH_W(16)) dut (
        .clk(clk), .rst(rst), .my_mac(my_mac), .pause_quanta(pause_quanta),
        .refresh_interval(refresh_interval), .pause_req(pause_req),
        .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(i_tready), .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready), .pause_sent(pause_sent), .xon_sent(xon_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Collects one 8-beat frame; with backpressure, records any change of a stalled beat.
    task automatic capture_frame(input int max_cycles, input bit use_pat);
        int n = 0;
        bit stalled = 1'b0;
        logic [63:0] sd;
        logic [3:0] su;
        logic sl;
        cap_beats = 0; cap_first = -1; cap_stall_err = 0; cap_start_cyc = -1;
        while (cap_beats < 8 && n < max_cycles) begin
            @(negedge clk);
            o_tready = use_pat ? ready_pat[n % 16] : 1'b1;
            #1;
            n++;
            if (stalled && (o_tvalid !== 1'b1 || o_tdata !== sd || o_tuser !== su || o_tlast !== sl))
                cap_stall_err++;
            stalled = 1'b0;
            if (o_tvalid === 1'b1) begin
                if (cap_first < 0) cap_first = n;
                if (o_tready) begin
                    if (cap_beats == 0) cap_start_cyc = cyc;
                    cap_data[cap_beats] = o_tdata;
                    cap_user[cap_beats] = o_tuser;
                    cap_last[cap_beats] = o_tlast;
                    cap_ps[cap_beats]   = pause_sent;
                    cap_xs[cap_beats]   = xon_sent;
                    cap_beats++;
                end else begin
                    stalled = 1'b1; sd = o_tdata; su = o_tuser; sl = o_tlast;
                end
            end
        end
        o_tready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; i_tvalid = 1'b1; i_tdata = 64'h1234; i_tlast = 1'b0; i_tuser = 4'd0;
        pause_req = 1'b0; o_tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (o_tvalid !== 1'b0 || i_tready !== 1'b0 || pause_sent !== 1'b0 || xon_sent !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got tvalid=%b tready=%b ps=%b xs=%b, want all 0",
                     o_tvalid, i_tready, pause_sent, xon_sent);
        end
        @(negedge clk); rst = 1'b0; i_tvalid = 1'b0; #1;
        checks++;
        if (o_tvalid !== 1'b0) begin
            errors++; $display("FAIL reset_idle: o_tvalid=%b, want 0", o_tvalid);
        end
    endtask

    task automatic test_xoff_frame;
        refresh_interval = 16'd0; my_mac = 48'h00802F16C52F; pause_quanta = 16'hFFFF;
        @(negedge clk); pause_req = 1'b1;
        capture_frame(40, 1'b0);
        checks++;
        if (cap_beats !== 8 || cap_first !== 2) begin
            errors++; $display("FAIL xoff_timing: beats=%0d first=%0d, want 8 and 2", cap_beats, cap_first);
        end
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (cap_data[b] !== exp_xoff[b] || cap_user[b] !== ((b == 7) ? 4'd4 : 4'd0) ||
                cap_last[b] !== (b == 7) || cap_ps[b] !== (b == 7) || cap_xs[b] !== 1'b0) begin
                errors++;
                $display("FAIL xoff_beat%0d: got data=%h user=%0d last=%b ps=%b xs=%b, want data=%h",
                         b, cap_data[b], cap_user[b], cap_last[b], cap_ps[b], cap_xs[b], exp_xoff[b]);
            end
        end
    endtask

    task automatic test_xon_frame;
        @(negedge clk); pause_req = 1'b0;
        capture_frame(40, 1'b0);
        checks++;
        if (cap_beats !== 8 || cap_first !== 2) begin
            errors++; $display("FAIL xon_timing: beats=%0d first=%0d, want 8 and 2", cap_beats, cap_first);
        end
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (cap_data[b] !== exp_xon[b] || cap_ps[b] !== (b == 7) || cap_xs[b] !== (b == 7)) begin
                errors++;
                $display("FAIL xon_beat%0d: got data=%h ps=%b xs=%b, want data=%h",
                         b, cap_data[b], cap_ps[b], cap_xs[b], exp_xon[b]);
            end
        end
    endtask

    task automatic test_refresh;
        int starts[4];
        refresh_interval = 16'd100;
        @(negedge clk); pause_req = 1'b1;
        for (int f = 0; f < 4; f++) begin
            capture_frame(150, 1'b0);
            starts[f] = cap_start_cyc;
            checks++;
            if (cap_beats !== 8 || cap_ps[7] !== 1'b1 || cap_data[2] !== exp_xoff[2]) begin
                errors++;
                $display("FAIL refresh_frame%0d: beats=%0d ps=%b q=%h, want 8 1 %h",
                         f, cap_beats, cap_ps[7], cap_data[2], exp_xoff[2]);
            end
        end
        for (int f = 1; f < 4; f++) begin
            checks++;
            if (starts[f] - starts[f-1] !== 100) begin
                errors++;
                $display("FAIL refresh_gap%0d: got %0d cycles, want 100", f, starts[f] - starts[f-1]);
            end
        end
        @(negedge clk); pause_req = 1'b0;
        capture_frame(40, 1'b0);
        refresh_interval = 16'd0;
        checks++;
        if (cap_beats !== 8 || cap_xs[7] !== 1'b1) begin
            errors++; $display("FAIL refresh_xon: beats=%0d xs=%b, want 8 1", cap_beats, cap_xs[7]);
        end
    endtask

    task automatic test_pass_then_xoff;
        logic [63:0] d;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            d = 64'hA5A5_0000_0000_0000 | 64'(k);
            i_tvalid = 1'b1; i_tdata = d; i_tlast = (k == 9); i_tuser = (k == 9) ? 4'd3 : 4'd0;
            if (k == 3) pause_req = 1'b1;
            #1;
            checks++;
            if (o_tvalid !== 1'b1 || i_tready !== 1'b1 || o_tdata !== d || o_tlast !== (k == 9) ||
                o_tuser !== ((k == 9) ? 4'd3 : 4'd0)) begin
                errors++;
                $display("FAIL pass_beat%0d: got v=%b rdy=%b data=%h last=%b, want 1 1 %h %b",
                         k, o_tvalid, i_tready, o_tdata, o_tlast, d, (k == 9));
            end
        end
        @(negedge clk); i_tdata = 64'hBEEF; i_tlast = 1'b1; i_tuser = 4'd0; i_tvalid = 1'b1; #1;
        checks++;
        if (o_tvalid !== 1'b0 || i_tready !== 1'b0) begin
            errors++; $display("FAIL pass_arb: got v=%b rdy=%b, want 0 0", o_tvalid, i_tready);
        end
        capture_frame(20, 1'b0);
        checks++;
        if (cap_beats !== 8 || cap_first !== 1 || cap_data[0] !== exp_xoff[0] || cap_data[2] !== exp_xoff[2]) begin
            errors++;
            $display("FAIL pass_xoff: beats=%0d first=%0d b0=%h b2=%h, want 8 1 %h %h",
                     cap_beats, cap_first, cap_data[0], cap_data[2], exp_xoff[0], exp_xoff[2]);
        end
        @(negedge clk); #1;
        checks++;
        if (o_tvalid !== 1'b1 || i_tready !== 1'b1 || o_tdata !== 64'hBEEF || o_tlast !== 1'b1) begin
            errors++;
            $display("FAIL pass_single: got v=%b rdy=%b data=%h last=%b, want 1 1 beef 1",
                     o_tvalid, i_tready, o_tdata, o_tlast);
        end
        @(negedge clk); i_tvalid = 1'b0; pause_req = 1'b0;
        capture_frame(40, 1'b0);
        checks++;
        if (cap_beats !== 8 || cap_xs[7] !== 1'b1) begin
            errors++; $display("FAIL pass_xon: beats=%0d xs=%b, want 8 1", cap_beats, cap_xs[7]);
        end
    endtask

    task automatic test_rise_fall_in_packet;
        logic [63:0] d;
        int extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            d = 64'h5A00_0000_0000_0000 | 64'(k);
            i_tvalid = 1'b1; i_tdata = d; i_tlast = (k == 5); i_tuser = 4'd0;
            if (k == 1) pause_req = 1'b1;
            if (k == 2) pause_req = 1'b0;
            #1;
            checks++;
            if (o_tvalid !== 1'b1 || o_tdata !== d || i_tready !== 1'b1) begin
                errors++;
                $display("FAIL glitch_pass%0d: got v=%b data=%h rdy=%b, want 1 %h 1", k, o_tvalid, o_tdata, i_tready, d);
            end
        end
        @(negedge clk); i_tvalid = 1'b0; #1;
        checks++;
        if (o_tvalid !== 1'b0) begin
            errors++; $display("FAIL glitch_idle: o_tvalid=%b, want 0", o_tvalid);
        end
        capture_frame(20, 1'b0);
        checks++;
        if (cap_beats !== 8 || cap_first !== 1 || cap_data[2] !== 64'd0 || cap_xs[7] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_xon: beats=%0d first=%0d q=%h xs=%b, want 8 1 0 1",
                     cap_beats, cap_first, cap_data[2], cap_xs[7]);
        end
        repeat (20) begin
            @(negedge clk); #1;
            if (o_tvalid === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL glitch_no_xoff: %0d valid cycles, want 0", extra);
        end
    endtask

    task automatic test_backpressure_reset;
        int acc = 0;
        int pulses = 0;
        @(negedge clk); pause_req = 1'b1;
        capture_frame(200, 1'b1);
        checks++;
        if (cap_beats !== 8 || cap_stall_err !== 0) begin
            errors++; $display("FAIL bp_frame: beats=%0d stall_changes=%0d, want 8 0", cap_beats, cap_stall_err);
        end
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (cap_data[b] !== exp_xoff[b] || cap_last[b] !== (b == 7) || cap_ps[b] !== (b == 7)) begin
                errors++;
                $display("FAIL bp_beat%0d: got data=%h last=%b ps=%b, want data=%h",
                         b, cap_data[b], cap_last[b], cap_ps[b], exp_xoff[b]);
            end
        end
        @(negedge clk); pause_req = 1'b0;
        for (int n = 0; n < 30 && acc < 4; n++) begin
            @(negedge clk); #1;
            if (pause_sent === 1'b1) pulses++;
            if (o_tvalid === 1'b1 && o_tready === 1'b1) acc++;
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (acc !== 4 || o_tvalid !== 1'b0 || i_tready !== 1'b0 || pulses !== 0 || pause_sent !== 1'b0) begin
            errors++;
            $display("FAIL rst_midframe: acc=%0d v=%b rdy=%b pulses=%0d, want 4 0 0 0",
                     acc, o_tvalid, i_tready, pulses);
        end
        @(negedge clk); i_tvalid = 1'b1; i_tdata = 64'hC0DE; i_tlast = 1'b1; #1;
        checks++;
        if (o_tvalid !== 1'b1 || i_tready !== 1'b1 || o_tdata !== 64'hC0DE) begin
            errors++;
            $display("FAIL rst_state_idle: got v=%b rdy=%b data=%h, want 1 1 c0de", o_tvalid, i_tready, o_tdata);
        end
        @(negedge clk); i_tvalid = 1'b0; pause_req = 1'b1;
        capture_frame(30, 1'b0);
        checks++;
        if (cap_beats !== 8 || cap_first !== 2 || cap_data[0] !== exp_xoff[0] || cap_last[7] !== 1'b1) begin
            errors++;
            $display("FAIL rst_next_frame: beats=%0d first=%0d b0=%h last=%b, want 8 2 %h 1",
                     cap_beats, cap_first, cap_data[0], cap_last[7], exp_xoff[0]);
        end
    endtask

    initial begin
        exp_xoff = '{64'h8000_0100_00C2_8001, 64'h0100_0888_2FC5_162F, 64'h0000_0000_0000_FFFF,
                     64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        exp_xon  = '{64'h8000_0100_00C2_8001, 64'h0100_0888_2FC5_162F, 64'd0,
                     64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
        my_mac = 48'h00802F16C52F; pause_quanta = 16'hFFFF; refresh_interval = 16'd0;
        test_reset();
        test_xoff_frame();
        test_xon_frame();
        test_refresh();
        test_pass_then_xoff();
        test_rise_fall_in_packet();
        test_backpressure_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
